// File: rtl/sr_serial_xfer_ctrl_if.sv
// Handshake and serial-link bundle between the transfer controller and its environment.
// The slave side is the controller; the master side is the producer/consumer/shift register.
interface sr_serial_xfer_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             ser_out;
  logic             ser_in;
  logic             sr_clr_n;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             out_ready;
  logic             busy;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output ser_out,
    input  ser_in,
    output sr_clr_n,
    output out_valid,
    output out_data,
    output out_err,
    input  out_ready,
    output busy
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  ser_out,
    output ser_in,
    input  sr_clr_n,
    input  out_valid,
    input  out_data,
    input  out_err,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/sr_serial_xfer_ctrl.sv
// Drives a parallel word LSB-first into a DEPTH-stage serial shift register, recaptures
// it at the far end, and flags any difference between the returned and sent word.
module sr_serial_xfer_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                clr,
  sr_serial_xfer_ctrl_if.slave bus
);

  localparam int CNT_W = ($clog2(WIDTH + DEPTH) < 1) ? 1 : $clog2(WIDTH + DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH + DEPTH - 1);
  localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] tx_word;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic             flush;
  logic [WIDTH-1:0] tx_next;
  logic [WIDTH-1:0] rx_next;

  function automatic logic word_mismatch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return |(a ^ b);
  endfunction

  // Next drive bit comes from the shifted-down tx word; ser_in enters rx from the MSB side.
  always_comb begin
    tx_next = tx_shift >> 1'b1;
    rx_next = WIDTH'({bus.ser_in, rx_shift} >> 1'b1);
  end

  // Controller state machine with all outputs registered; clr overrides every handshake.
  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= IDLE;
      cnt           <= '0;
      tx_word       <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      flush         <= 1'b1;
      bus.in_ready  <= 1'b0;
      bus.ser_out   <= 1'b0;
      bus.sr_clr_n  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_err   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      // Hold the datapath clear for one extra cycle after clr drops.
      bus.sr_clr_n <= ~flush;
      flush        <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            tx_word      <= bus.in_data;
            tx_shift     <= bus.in_data;
            cnt          <= '0;
            bus.ser_out  <= bus.in_data[0];
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= XFER;
          end else begin
            bus.ser_out  <= 1'b0;
            bus.in_ready <= ~flush;
            bus.busy     <= 1'b0;
          end
        end
        XFER: begin
          tx_shift <= tx_next;
          if (cnt >= CAP_FIRST) begin
            rx_shift <= rx_next;
          end else begin
            rx_shift <= rx_shift;
          end
          if (cnt == CNT_LAST) begin
            bus.ser_out   <= 1'b0;
            bus.out_data  <= rx_next;
            bus.out_err   <= word_mismatch(rx_next, tx_word);
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            bus.ser_out <= tx_next[0];
            cnt         <= cnt + CNT_ONE;
          end
        end
        DONE: begin
          bus.ser_out <= 1'b0;
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          cnt           <= '0;
          bus.ser_out   <= 1'b0;
          bus.in_ready  <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_serial_xfer_ctrl.sv
// Directed bench: two controllers (4x4 and 8x3) each looped through an ideal shift-register
// model; the 4x4 model can force one returned bit high to provoke a mismatch.
module tb_sr_serial_xfer_ctrl;

  logic clk;
  logic clr;
  logic force_a;
  int   checks;
  int   errors;

  logic [3:0] chain_a;
  logic [2:0] chain_b;
  logic [3:0] word_c;
  logic [7:0] word_a5;

  sr_serial_xfer_ctrl_if #(.WIDTH(4)) bus_a ();
  sr_serial_xfer_ctrl_if #(.WIDTH(8)) bus_b ();

  sr_serial_xfer_ctrl #(.WIDTH(4), .DEPTH(4)) dut_a (.clk(clk), .clr(clr), .bus(bus_a));
  sr_serial_xfer_ctrl #(.WIDTH(8), .DEPTH(3)) dut_b (.clk(clk), .clr(clr), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal shift registers with synchronous clear from the controller.
  always @(posedge clk) begin
    if (!bus_a.sr_clr_n) chain_a <= 4'd0;
    else                 chain_a <= {chain_a[2:0], bus_a.ser_out};
    if (!bus_b.sr_clr_n) chain_b <= 3'd0;
    else                 chain_b <= {chain_b[1:0], bus_b.ser_out};
  end

  assign bus_a.ser_in = chain_a[3] | force_a;
  assign bus_b.ser_in = chain_b[2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    force_a = 1'b0;
    word_c = 4'hC;
    word_a5 = 8'hA5;
    clr = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = 4'h0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00; bus_b.out_ready = 1'b0;

    // Reset: three cycles of clr, then the flush cycle.
    tick;
    check("rst_sr_clr_n", 32'(bus_a.sr_clr_n), 32'd0);
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    tick;
    tick;
    check("rst_sr_clr_n_3", 32'(bus_a.sr_clr_n), 32'd0);
    clr = 1'b0;
    tick;
    check("flush_sr_clr_n", 32'(bus_a.sr_clr_n), 32'd0);
    check("flush_in_ready", 32'(bus_a.in_ready), 32'd0);
    tick;
    check("post_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("post_sr_clr_n", 32'(bus_a.sr_clr_n), 32'd1);
    check("post_ser_out", 32'(bus_a.ser_out), 32'd0);
    check("post_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("post_out_data", 32'(bus_a.out_data), 32'd0);
    check("post_out_err", 32'(bus_a.out_err), 32'd0);
    check("post_busy", 32'(bus_a.busy), 32'd0);
    check("post_b_in_ready", 32'(bus_b.in_ready), 32'd1);

    // Basic transfer of 4'b1100.
    bus_a.in_valid = 1'b1; bus_a.in_data = 4'hC;
    tick;
    bus_a.in_valid = 1'b0;
    check("basic_ser_out_0", 32'(bus_a.ser_out), 32'd0);
    check("basic_busy", 32'(bus_a.busy), 32'd1);
    check("basic_in_ready", 32'(bus_a.in_ready), 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick;
      check("basic_ser_out", 32'(bus_a.ser_out), 32'(word_c[k]));
    end
    for (int k = 4; k < 8; k++) begin
      tick;
      check("basic_ser_out_tail", 32'(bus_a.ser_out), 32'd0);
      check("basic_early_valid", 32'(bus_a.out_valid), 32'd0);
    end
    tick;
    check("basic_out_valid", 32'(bus_a.out_valid), 32'd1);
    check("basic_out_data", 32'(bus_a.out_data), 32'hC);
    check("basic_out_err", 32'(bus_a.out_err), 32'd0);

    // Backpressure with a new word offered during DONE.
    bus_a.in_valid = 1'b1; bus_a.in_data = 4'h5;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("bp_out_valid", 32'(bus_a.out_valid), 32'd1);
      check("bp_out_data", 32'(bus_a.out_data), 32'hC);
      check("bp_out_err", 32'(bus_a.out_err), 32'd0);
      check("bp_in_ready", 32'(bus_a.in_ready), 32'd0);
    end
    bus_a.out_ready = 1'b1;
    tick;
    bus_a.out_ready = 1'b0;
    check("bp_hs_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("bp_hs_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("bp_hs_busy", 32'(bus_a.busy), 32'd0);
    check("bp_hs_data_kept", 32'(bus_a.out_data), 32'hC);
    tick;
    bus_a.in_valid = 1'b0;
    check("bp_accept_busy", 32'(bus_a.busy), 32'd1);
    check("bp_accept_ser_out", 32'(bus_a.ser_out), 32'd1);
    for (int k = 1; k < 8; k++) begin
      tick;
      check("bp_early_valid", 32'(bus_a.out_valid), 32'd0);
    end
    tick;
    check("bp2_out_valid", 32'(bus_a.out_valid), 32'd1);
    check("bp2_out_data", 32'(bus_a.out_data), 32'h5);
    check("bp2_out_err", 32'(bus_a.out_err), 32'd0);
    bus_a.out_ready = 1'b1;
    tick;
    bus_a.out_ready = 1'b0;

    // Error detect: returned bit 2 forced high, 4'h3 comes back as 4'h7.
    bus_a.in_valid = 1'b1; bus_a.in_data = 4'h3;
    tick;
    bus_a.in_valid = 1'b0;
    repeat (6) tick;
    force_a = 1'b1;
    tick;
    force_a = 1'b0;
    tick;
    check("err_out_valid", 32'(bus_a.out_valid), 32'd1);
    check("err_out_data", 32'(bus_a.out_data), 32'h7);
    check("err_out_err", 32'(bus_a.out_err), 32'd1);
    bus_a.out_ready = 1'b1;
    tick;
    bus_a.out_ready = 1'b0;

    // clr in XFER at cnt=5.
    bus_a.in_valid = 1'b1; bus_a.in_data = 4'hE;
    tick;
    bus_a.in_valid = 1'b0;
    repeat (5) tick;
    check("mid_busy_before", 32'(bus_a.busy), 32'd1);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    check("mid_busy", 32'(bus_a.busy), 32'd0);
    check("mid_ser_out", 32'(bus_a.ser_out), 32'd0);
    check("mid_sr_clr_n", 32'(bus_a.sr_clr_n), 32'd0);
    check("mid_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("mid_out_data", 32'(bus_a.out_data), 32'd0);
    check("mid_in_ready", 32'(bus_a.in_ready), 32'd0);
    tick;
    check("mid_flush_sr_clr_n", 32'(bus_a.sr_clr_n), 32'd0);
    check("mid_flush_in_ready", 32'(bus_a.in_ready), 32'd0);
    tick;
    check("mid_post_sr_clr_n", 32'(bus_a.sr_clr_n), 32'd1);
    check("mid_post_in_ready", 32'(bus_a.in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("mid_no_valid", 32'(bus_a.out_valid), 32'd0);
    end
    bus_a.in_valid = 1'b1; bus_a.in_data = 4'hA;
    tick;
    bus_a.in_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick;
      check("mid2_early_valid", 32'(bus_a.out_valid), 32'd0);
    end
    tick;
    check("mid2_out_valid", 32'(bus_a.out_valid), 32'd1);
    check("mid2_out_data", 32'(bus_a.out_data), 32'hA);
    check("mid2_out_err", 32'(bus_a.out_err), 32'd0);
    bus_a.out_ready = 1'b1;
    tick;
    bus_a.out_ready = 1'b0;

    // clr wins over an accept in the same cycle.
    bus_a.in_valid = 1'b1; bus_a.in_data = 4'hF;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    bus_a.in_valid = 1'b0;
    check("prio_busy", 32'(bus_a.busy), 32'd0);
    check("prio_in_ready", 32'(bus_a.in_ready), 32'd0);
    tick;
    tick;
    check("prio_post_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("prio_post_busy", 32'(bus_a.busy), 32'd0);

    // Sweep: WIDTH=8, DEPTH=3, 8'hA5.
    bus_b.in_valid = 1'b1; bus_b.in_data = 8'hA5;
    tick;
    bus_b.in_valid = 1'b0;
    check("sw_ser_out_0", 32'(bus_b.ser_out), 32'd1);
    for (int k = 1; k < 8; k++) begin
      tick;
      check("sw_ser_out", 32'(bus_b.ser_out), 32'(word_a5[k]));
    end
    for (int k = 8; k < 11; k++) begin
      tick;
      check("sw_early_valid", 32'(bus_b.out_valid), 32'd0);
    end
    tick;
    check("sw_out_valid", 32'(bus_b.out_valid), 32'd1);
    check("sw_out_data", 32'(bus_b.out_data), 32'hA5);
    check("sw_out_err", 32'(bus_b.out_err), 32'd0);
    bus_b.out_ready = 1'b1;
    tick;
    bus_b.out_ready = 1'b0;
    check("sw_hs_out_valid", 32'(bus_b.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
